// File: rtl/sd_bd_buffer_if.sv
// Bus bundle between the BD buffer, the host writer and the SD data master.
// slave = the buffer itself; master = whoever drives it (host + data master).
interface sd_bd_buffer_if #(
    parameter int RAM_MEM_WIDTH = 32,
    parameter int BD_WIDTH      = 5
);
    logic                     we_m;
    logic [RAM_MEM_WIDTH-1:0] dat_in_m;
    logic                     bd_clr;
    logic                     wr_ovf;
    logic [BD_WIDTH-1:0]      free_bd;
    logic                     re_s;
    logic                     ack_i_s;
    logic [RAM_MEM_WIDTH-1:0] dat_out_s;
    logic                     a_cmp;
    logic                     bd_done_int;

    modport slave (
        input  we_m, dat_in_m, bd_clr, re_s, a_cmp,
        output wr_ovf, free_bd, ack_i_s, dat_out_s, bd_done_int
    );

    modport master (
        output we_m, dat_in_m, bd_clr, re_s, a_cmp,
        input  wr_ovf, free_bd, ack_i_s, dat_out_s, bd_done_int
    );
endinterface

// File: rtl/sd_bd_buffer.sv
// Two-word buffer-descriptor ring feeding the SD data master; descriptors are
// published only when complete and freed only on the master's completion pulse.
module sd_bd_buffer #(
    parameter int RAM_MEM_WIDTH = 32,
    parameter int BD_SIZE       = 16,
    parameter int BD_WIDTH      = 5
) (
    input  logic          clk,
    input  logic          rst,
    sd_bd_buffer_if.slave bus
);
    localparam int AW = $clog2(BD_SIZE);
    localparam int CW = AW + 1;
    localparam logic [BD_WIDTH-1:0] HALF = BD_WIDTH'(BD_SIZE / 2);

    logic [RAM_MEM_WIDTH-1:0] mem [BD_SIZE];

    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic                     wr_half_q, wr_half_d;
    logic                     rd_half_q, rd_half_d;
    logic [CW-1:0]            avail_q, avail_d;
    logic [BD_WIDTH-1:0]      in_svc_q, in_svc_d;
    logic [BD_WIDTH-1:0]      free_q, free_d;
    logic                     ack_q, ovf_q, done_q;
    logic [RAM_MEM_WIDTH-1:0] dout_q;

    logic wr_acc, wr_rej, wr_commit, rd_acc, cmp_acc, svc_inc;

    // Full-store check uses the pre-update free count, so a same-cycle
    // completion cannot make room for a write.
    assign wr_acc    = bus.we_m && (free_q != '0) && !bus.bd_clr;
    assign wr_rej    = bus.we_m && (free_q == '0) && !bus.bd_clr;
    assign wr_commit = wr_acc && wr_half_q;
    assign rd_acc    = bus.re_s && (avail_q != '0) && !ack_q && !bus.bd_clr;
    assign cmp_acc   = bus.a_cmp && (in_svc_q != '0) && !bus.bd_clr;
    assign svc_inc   = rd_acc && rd_half_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_half_d = wr_half_q;
        rd_ptr_d  = rd_ptr_q;
        rd_half_d = rd_half_q;
        avail_d   = avail_q;
        free_d    = free_q;
        in_svc_d  = in_svc_q;
        if (wr_acc) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            wr_half_d = ~wr_half_q;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_half_d = ~rd_half_q;
        end
        if (wr_commit) begin
            avail_d = avail_d + CW'(2);
            free_d  = free_d - 1'b1;
        end
        if (rd_acc)  avail_d  = avail_d - CW'(1);
        if (svc_inc) in_svc_d = in_svc_d + 1'b1;
        if (cmp_acc) begin
            in_svc_d = in_svc_d - 1'b1;
            free_d   = free_d + 1'b1;
        end
    end

    // Plain RAM: no reset so it can map onto block/distributed memory.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.dat_in_m;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_half_q <= 1'b0;
            rd_half_q <= 1'b0;
            avail_q   <= '0;
            in_svc_q  <= '0;
            free_q    <= HALF;
            ack_q     <= 1'b0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.bd_clr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_half_q <= 1'b0;
            rd_half_q <= 1'b0;
            avail_q   <= '0;
            in_svc_q  <= '0;
            free_q    <= HALF;
            ack_q     <= 1'b0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_half_q <= wr_half_d;
            rd_half_q <= rd_half_d;
            avail_q   <= avail_d;
            in_svc_q  <= in_svc_d;
            free_q    <= free_d;
            ack_q     <= rd_acc;
            if (rd_acc) dout_q <= mem[rd_ptr_q];
            if (wr_rej) ovf_q <= 1'b1;
            done_q    <= cmp_acc;
        end
    end

    assign bus.ack_i_s     = ack_q;
    assign bus.dat_out_s   = dout_q;
    assign bus.free_bd     = free_q;
    assign bus.wr_ovf      = ovf_q;
    assign bus.bd_done_int = done_q;
endmodule

// File: tb/tb_sd_bd_buffer.sv
// Directed bench for sd_bd_buffer: reset, basic fetch, full/wrap, same-cycle
// events, idle completion, flush and mid-read reset.
module tb_sd_bd_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    sd_bd_buffer_if #(.RAM_MEM_WIDTH(32), .BD_WIDTH(5)) bus ();

    sd_bd_buffer #(.RAM_MEM_WIDTH(32), .BD_SIZE(16), .BD_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic write_word(input logic [31:0] d);
        bus.we_m     = 1'b1;
        bus.dat_in_m = d;
        @(posedge clk); #1;
        bus.we_m     = 1'b0;
    endtask

    task automatic pulse_cmp();
        bus.a_cmp = 1'b1;
        @(posedge clk); #1;
        bus.a_cmp = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.bd_clr = 1'b1;
        @(posedge clk); #1;
        bus.bd_clr = 1'b0;
    endtask

    // Holds re_s high and waits (bounded) for the next ack; leaves re_s high.
    task automatic get_word(output logic [31:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        bus.re_s = 1'b1;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.ack_i_s === 1'b1) begin
                ok = 1'b1;
                d  = bus.dat_out_s;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.free_bd !== 5'd8) $display("FAIL reset_free got %0d exp 8", bus.free_bd);
        else pass_cnt++;
        total_cnt++;
        if (bus.ack_i_s !== 1'b0 || bus.wr_ovf !== 1'b0 || bus.bd_done_int !== 1'b0)
            $display("FAIL reset_flags got ack=%b ovf=%b done=%b exp 0 0 0",
                     bus.ack_i_s, bus.wr_ovf, bus.bd_done_int);
        else pass_cnt++;
        total_cnt++;
        if (bus.dat_out_s !== 32'h0) $display("FAIL reset_dout got %h exp 0", bus.dat_out_s);
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bit ok, extra;
        write_word(32'h0000_1000);
        total_cnt++;
        if (bus.free_bd !== 5'd8) $display("FAIL basic_half_free got %0d exp 8", bus.free_bd);
        else pass_cnt++;
        write_word(32'h0000_0200);
        total_cnt++;
        if (bus.free_bd !== 5'd7) $display("FAIL basic_full_free got %0d exp 7", bus.free_bd);
        else pass_cnt++;
        get_word(d, ok);
        total_cnt++;
        if (!ok || d !== 32'h0000_1000) $display("FAIL basic_rd0 got %h ok=%0b exp 00001000", d, ok);
        else pass_cnt++;
        // Ack must drop for one cycle between words.
        @(posedge clk); #1;
        total_cnt++;
        if (bus.ack_i_s !== 1'b0) $display("FAIL basic_ack_gap got %b exp 0", bus.ack_i_s);
        else pass_cnt++;
        get_word(d, ok);
        total_cnt++;
        if (!ok || d !== 32'h0000_0200) $display("FAIL basic_rd1 got %h ok=%0b exp 00000200", d, ok);
        else pass_cnt++;
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack_i_s === 1'b1) extra = 1'b1;
        end
        bus.re_s = 1'b0;
        total_cnt++;
        if (extra) $display("FAIL basic_no_third_ack got ack exp none");
        else pass_cnt++;
        pulse_cmp();
        total_cnt++;
        if (bus.free_bd !== 5'd8 || bus.bd_done_int !== 1'b1)
            $display("FAIL basic_cmp got free=%0d done=%b exp 8 1", bus.free_bd, bus.bd_done_int);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.bd_done_int !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", bus.bd_done_int);
        else pass_cnt++;
    endtask

    task automatic test_full_wrap();
        logic [31:0] d, exp_d;
        bit ok;
        pulse_clr();
        for (int i = 0; i < 16; i++) write_word(32'hA000 + i);
        total_cnt++;
        if (bus.free_bd !== 5'd0) $display("FAIL full_free got %0d exp 0", bus.free_bd);
        else pass_cnt++;
        write_word(32'hDEAD);
        total_cnt++;
        if (bus.wr_ovf !== 1'b1 || bus.free_bd !== 5'd0)
            $display("FAIL full_ovf got ovf=%b free=%0d exp 1 0", bus.wr_ovf, bus.free_bd);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            get_word(d, ok);
            total_cnt++;
            if (!ok || d !== 32'hA000 + i) $display("FAIL full_rd%0d got %h exp %h", i, d, 32'hA000 + i);
            else pass_cnt++;
        end
        bus.re_s = 1'b0;
        pulse_cmp();
        total_cnt++;
        if (bus.free_bd !== 5'd1) $display("FAIL full_cmp_free got %0d exp 1", bus.free_bd);
        else pass_cnt++;
        write_word(32'hB000);
        write_word(32'hB001);
        total_cnt++;
        if (bus.free_bd !== 5'd0) $display("FAIL wrap_free got %0d exp 0", bus.free_bd);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 14) ? 32'hA002 + i : 32'hB000 + (i - 14);
            get_word(d, ok);
            total_cnt++;
            if (!ok || d !== exp_d) $display("FAIL wrap_rd%0d got %h ok=%0b exp %h", i, d, ok, exp_d);
            else pass_cnt++;
        end
        bus.re_s = 1'b0;
        bus.a_cmp = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        bus.a_cmp = 1'b0;
        total_cnt++;
        if (bus.free_bd !== 5'd8 || bus.wr_ovf !== 1'b1)
            $display("FAIL wrap_drain got free=%0d ovf=%b exp 8 1", bus.free_bd, bus.wr_ovf);
        else pass_cnt++;
        pulse_clr();
        total_cnt++;
        if (bus.wr_ovf !== 1'b0) $display("FAIL clr_ovf got %b exp 0", bus.wr_ovf);
        else pass_cnt++;
    endtask

    task automatic test_simul();
        logic [31:0] d;
        bit ok;
        for (int i = 0; i < 6; i++) write_word(32'h5000 + i);
        get_word(d, ok);
        get_word(d, ok);
        bus.re_s = 1'b0;
        total_cnt++;
        if (!ok || bus.free_bd !== 5'd5) $display("FAIL simul_setup got free=%0d ok=%0b exp 5 1", bus.free_bd, ok);
        else pass_cnt++;
        write_word(32'h6000);
        bus.we_m     = 1'b1;
        bus.dat_in_m = 32'h6001;
        bus.a_cmp    = 1'b1;
        @(posedge clk); #1;
        bus.we_m  = 1'b0;
        bus.a_cmp = 1'b0;
        total_cnt++;
        if (bus.free_bd !== 5'd5 || bus.bd_done_int !== 1'b1)
            $display("FAIL simul_wr_cmp got free=%0d done=%b exp 5 1", bus.free_bd, bus.bd_done_int);
        else pass_cnt++;
        pulse_clr();
    endtask

    task automatic test_cmp_idle();
        pulse_cmp();
        total_cnt++;
        if (bus.free_bd !== 5'd8 || bus.bd_done_int !== 1'b0)
            $display("FAIL idle_cmp got free=%0d done=%b exp 8 0", bus.free_bd, bus.bd_done_int);
        else pass_cnt++;
    endtask

    task automatic test_clr();
        logic [31:0] d;
        bit ok, seen;
        for (int i = 0; i < 6; i++) write_word(32'h7000 + i);
        get_word(d, ok);
        bus.re_s = 1'b0;
        write_word(32'h7777);  // half descriptor, must be aborted
        bus.bd_clr   = 1'b1;
        bus.we_m     = 1'b1;
        bus.dat_in_m = 32'h7FFF;
        @(posedge clk); #1;
        bus.bd_clr = 1'b0;
        bus.we_m   = 1'b0;
        total_cnt++;
        if (bus.free_bd !== 5'd8 || bus.ack_i_s !== 1'b0 || bus.wr_ovf !== 1'b0)
            $display("FAIL clr_state got free=%0d ack=%b ovf=%b exp 8 0 0",
                     bus.free_bd, bus.ack_i_s, bus.wr_ovf);
        else pass_cnt++;
        bus.re_s = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack_i_s === 1'b1) seen = 1'b1;
        end
        bus.re_s = 1'b0;
        total_cnt++;
        if (seen) $display("FAIL clr_no_ack got ack exp none");
        else pass_cnt++;
        write_word(32'hC000);
        write_word(32'hC001);
        get_word(d, ok);
        total_cnt++;
        if (!ok || d !== 32'hC000) $display("FAIL clr_rd0 got %h ok=%0b exp 0000c000", d, ok);
        else pass_cnt++;
        get_word(d, ok);
        bus.re_s = 1'b0;
        total_cnt++;
        if (!ok || d !== 32'hC001) $display("FAIL clr_rd1 got %h ok=%0b exp 0000c001", d, ok);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        pulse_clr();
        write_word(32'hE000);
        write_word(32'hE001);
        bus.re_s = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.ack_i_s !== 1'b1) $display("FAIL mid_ack got %b exp 1", bus.ack_i_s);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.ack_i_s !== 1'b0 || bus.free_bd !== 5'd8)
            $display("FAIL mid_reset got ack=%b free=%0d exp 0 8", bus.ack_i_s, bus.free_bd);
        else pass_cnt++;
        bus.re_s = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.we_m     = 1'b0;
        bus.dat_in_m = '0;
        bus.bd_clr   = 1'b0;
        bus.re_s     = 1'b0;
        bus.a_cmp    = 1'b0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_simul();
        test_cmp_idle();
        test_clr();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
